ins_sequencer: RTL
==================

Name: ins_sequencer

Overview:
- Fetch/decode/execute control sequencer for the 4-bit-parameter processor.
- Sits directly upstream of the parameter router. It supplies the 4-bit PARAM and the 2-bit route select consumed by the router, and it issues the strobes for the address, jump/PC and add/sub units.
- Fetches 8-bit instructions from a synchronous-read instruction memory. Holds PARAM/select stable for the whole execute phase.
- Waits on a datapath done handshake, with a timeout.

Parameters:
- IW, 8, instruction width; opcode = [7:4], param = [3:0].
- TIMEOUT, 15, maximum cycles spent in WAIT_DONE before a fault; must be ≥ 1.
- TW, 4, width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; leaves IDLE or HALT.
- fetch_req  out  1  instruction-memory read strobe; data is valid the following cycle.
- ins_in  in  IW  instruction-memory read data.
- exec_done  in  1  datapath completion pulse for multi-cycle ops.
- zero_flag  in  1  accumulator-zero status, sampled in EXEC.
- PARAM  out  4  param field, registered.
- prm_sel  out  2  route select: 0 none, 1 adr, 2 jmp, 3 add_sub.
- pc_inc  out  1  PC increment strobe.
- jmp_load  out  1  PC load-from-jump strobe.
- mem_rd  out  1  data read strobe (LDA).
- mem_wr  out  1  data write strobe (STA).
- alu_op  out  2  0 none, 1 add, 2 sub.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- fault  out  1  sticky; set on timeout, cleared only by rst.
- halted  out  1  high while in HALT.

Behaviour:
- Reset: state = IDLE. Every output is 0, the instruction register is 0 and the timeout counter is 0. rst asserted mid-operation aborts immediately, with no completion strobes.
- All outputs are registered and change only on a clk edge.

Opcodes:
- 0 NOP.
- 1 LDA: select adr, strobe mem_rd.
- 2 STA: select adr, strobe mem_wr.
- 3 JMP: select jmp.
- 4 JZ: select jmp only when taken.
- 5 ADD: select add_sub, alu_op = 1.
- 6 SUB: select add_sub, alu_op = 2.
- F HALT.
- Codes 7–E are illegal: executed as NOP, plus a one-cycle illegal pulse.

State machine:
- IDLE: waits for start, then goes to FETCH.
- FETCH: fetch_req = 1 for exactly one cycle, then LATCH.
- LATCH: captures ins_in into the instruction register, then DECODE.
- DECODE:
  - Loads PARAM = IR[3:0] and prm_sel per opcode.
  - For NOP, illegal opcodes and not-taken JZ: PARAM is still loaded, but prm_sel = 0.
  - Next state is EXEC.
- EXEC: a single cycle with the operation strobes.
  - JMP, and JZ with zero_flag = 1: jmp_load = 1, pc_inc = 0.
  - All others: pc_inc = 1.
  - LDA/STA/ADD/SUB: mem_rd / mem_wr / alu_op asserted this cycle, then WAIT_DONE.
  - HALT: no pc_inc; goes to HALT.
  - Everything else: goes to FETCH.
- WAIT_DONE:
  - Timeout counter increments each cycle.
  - exec_done = 1 → FETCH, counter cleared.
  - Counter reaches TIMEOUT without exec_done → fault = 1, go to HALT.
  - If exec_done arrives in the same cycle the counter reaches TIMEOUT, done wins and no fault is raised.
- HALT: halted = 1, prm_sel = 0. start → FETCH (resume at the next PC); halted drops that cycle.
- start is ignored in every state other than IDLE and HALT.
- exec_done is ignored outside WAIT_DONE.

Hold and strobe rules:
- PARAM/prm_sel are held from DECODE through the end of EXEC or WAIT_DONE. They return to prm_sel = 0 on entry to FETCH; PARAM is retained.
- pc_inc, jmp_load, mem_rd, mem_wr and alu_op are strobes, high only in the EXEC cycle.
- Instruction throughput is 4 cycles for single-cycle ops, plus WAIT_DONE cycles for multi-cycle ops.

Decomposition:
- Shared include define.v gets: the opcode constants (op_nop … op_halt), the state encodings (st_idle … st_halt), and the prm_sel codes as prm_none/prm_adr/prm_jmp/prm_add_sub = 0..3. The prm_sel codes are shared with the router, which consumes them.
- One natural sub-module, ins_decode: purely combinational, mapping opcode and zero_flag to the select/strobe/illegal vector. The sequencer registers that vector.

Test Plan:
- Reset, then start; ins_in = 8'h35 (JMP 5) → fetch_req in cycle 1. DECODE gives PARAM = 5, prm_sel = 2. EXEC gives jmp_load = 1, pc_inc = 0, then back to FETCH.
- ins_in = 8'h4A with zero_flag = 0 → prm_sel = 0, pc_inc = 1, jmp_load = 0. Repeat with zero_flag = 1 → prm_sel = 2, PARAM = A, jmp_load = 1.
- ins_in = 8'h53 (ADD 3), exec_done after 4 cycles → alu_op = 1 for one cycle. prm_sel = 3 and PARAM = 3 are held until exec_done, then FETCH; fault stays 0.
- ins_in = 8'h62 (SUB 2) with exec_done never asserted → fault = 1 after TIMEOUT = 15 WAIT_DONE cycles, then halted = 1. A later start resumes FETCH and fault stays 1.
- ins_in = 8'h9C → illegal pulses for 1 cycle, prm_sel = 0, pc_inc = 1. Then ins_in = 8'hF0 → halted = 1, no pc_inc.
- rst asserted asynchronously mid-WAIT_DONE → all outputs 0 immediately, state IDLE. A start pulse during WAIT_DONE has no effect.

Source files
------------

// File: rtl/ins_sequencer_pkg.sv
// Shared opcode, state and route-select encodings for the instruction sequencer.
// The prm_* codes are also consumed by the downstream parameter router.
package ins_sequencer_pkg;

    localparam logic [3:0] op_nop  = 4'h0;
    localparam logic [3:0] op_lda  = 4'h1;
    localparam logic [3:0] op_sta  = 4'h2;
    localparam logic [3:0] op_jmp  = 4'h3;
    localparam logic [3:0] op_jz   = 4'h4;
    localparam logic [3:0] op_add  = 4'h5;
    localparam logic [3:0] op_sub  = 4'h6;
    localparam logic [3:0] op_halt = 4'hF;

    localparam logic [1:0] prm_none    = 2'd0;
    localparam logic [1:0] prm_adr     = 2'd1;
    localparam logic [1:0] prm_jmp     = 2'd2;
    localparam logic [1:0] prm_add_sub = 2'd3;

    localparam logic [1:0] alu_none = 2'd0;
    localparam logic [1:0] alu_add  = 2'd1;
    localparam logic [1:0] alu_sub  = 2'd2;

    typedef enum logic [2:0] {
        st_idle      = 3'd0,
        st_fetch     = 3'd1,
        st_latch     = 3'd2,
        st_decode    = 3'd3,
        st_exec      = 3'd4,
        st_wait_done = 3'd5,
        st_halt      = 3'd6
    } state_e;

    typedef struct packed {
        logic [1:0] prm_sel;
        logic       pc_inc;
        logic       jmp_load;
        logic       mem_rd;
        logic       mem_wr;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    // Opcodes that park in WAIT_DONE until the datapath reports completion.
    function automatic logic is_multi(input logic [3:0] op);
        return (op == op_lda) || (op == op_sta) || (op == op_add) || (op == op_sub);
    endfunction

endpackage

// File: rtl/ins_decode.sv
// Combinational opcode decoder: opcode and zero flag to route select and
// execute-phase strobes. The sequencer registers this vector.
module ins_decode
    import ins_sequencer_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       zero_flag,
    output ctrl_t      ctrl
);

    // Map each opcode to its select and strobe set.
    always_comb begin
        ctrl = '0;
        case (opcode)
            op_nop: begin
                ctrl.pc_inc = 1'b1;
            end
            op_lda: begin
                ctrl.prm_sel = prm_adr;
                ctrl.mem_rd  = 1'b1;
                ctrl.pc_inc  = 1'b1;
            end
            op_sta: begin
                ctrl.prm_sel = prm_adr;
                ctrl.mem_wr  = 1'b1;
                ctrl.pc_inc  = 1'b1;
            end
            op_jmp: begin
                ctrl.prm_sel  = prm_jmp;
                ctrl.jmp_load = 1'b1;
            end
            op_jz: begin
                if (zero_flag) begin
                    ctrl.prm_sel  = prm_jmp;
                    ctrl.jmp_load = 1'b1;
                end else begin
                    ctrl.pc_inc = 1'b1;
                end
            end
            op_add: begin
                ctrl.prm_sel = prm_add_sub;
                ctrl.alu_op  = alu_add;
                ctrl.pc_inc  = 1'b1;
            end
            op_sub: begin
                ctrl.prm_sel = prm_add_sub;
                ctrl.alu_op  = alu_sub;
                ctrl.pc_inc  = 1'b1;
            end
            op_halt: begin
                ctrl.pc_inc = 1'b0;
            end
            default: begin
                ctrl.illegal = 1'b1;
                ctrl.pc_inc  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ins_sequencer.sv
// Fetch/decode/execute control sequencer feeding the parameter router and
// the address, PC and add/sub units. All outputs come straight from flops.
module ins_sequencer
    import ins_sequencer_pkg::*;
#(
    parameter int IW      = 8,
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          fetch_req,
    input  logic [IW-1:0] ins_in,
    input  logic          exec_done,
    input  logic          zero_flag,
    output logic [3:0]    PARAM,
    output logic [1:0]    prm_sel,
    output logic          pc_inc,
    output logic          jmp_load,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [1:0]    alu_op,
    output logic          illegal,
    output logic          fault,
    output logic          halted
);

    localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);

    state_e        state_q, state_d;
    logic [IW-1:0] ir_q, ir_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          fault_q, fault_d;
    logic          fetch_req_q, fetch_req_d;
    logic          halted_q, halted_d;
    logic [3:0]    param_q, param_d;
    ctrl_t         ctrl_q, ctrl_d;
    ctrl_t         dec_ctrl;
    logic [3:0]    opcode;
    logic [TW-1:0] cnt_inc;

    assign opcode  = ir_q[7:4];
    assign cnt_inc = cnt_q + TW'(1);

    ins_decode u_decode (
        .opcode    (opcode),
        .zero_flag (zero_flag),
        .ctrl      (dec_ctrl)
    );

    // State, instruction register, timeout counter and sticky fault.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= st_idle;
            ir_q    <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Next-state logic, including the WAIT_DONE timeout where done wins a tie.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        case (state_q)
            st_idle: begin
                if (start) state_d = st_fetch;
                else       state_d = st_idle;
            end
            st_fetch:  state_d = st_latch;
            st_latch: begin
                ir_d    = ins_in;
                state_d = st_decode;
            end
            st_decode: state_d = st_exec;
            st_exec: begin
                if (opcode == op_halt) begin
                    state_d = st_halt;
                end else if (is_multi(opcode)) begin
                    state_d = st_wait_done;
                    cnt_d   = '0;
                end else begin
                    state_d = st_fetch;
                end
            end
            st_wait_done: begin
                if (exec_done) begin
                    state_d = st_fetch;
                    cnt_d   = '0;
                end else if (cnt_inc == TIMEOUT_V) begin
                    state_d = st_halt;
                    cnt_d   = '0;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            st_halt: begin
                if (start) state_d = st_fetch;
                else       state_d = st_halt;
            end
            default: state_d = st_idle;
        endcase
    end

    // Output values for the coming state; zero_flag is captured as EXEC begins.
    always_comb begin
        fetch_req_d    = (state_d == st_fetch);
        halted_d       = (state_d == st_halt);
        param_d        = param_q;
        ctrl_d         = '0;
        ctrl_d.prm_sel = ctrl_q.prm_sel;
        if (state_q == st_decode) begin
            param_d = ir_q[3:0];
            ctrl_d  = dec_ctrl;
        end else if ((state_d == st_fetch) || (state_d == st_halt) || (state_d == st_idle)) begin
            ctrl_d.prm_sel = prm_none;
        end else begin
            ctrl_d.prm_sel = ctrl_q.prm_sel;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_req_q <= 1'b0;
            halted_q    <= 1'b0;
            param_q     <= 4'h0;
            ctrl_q      <= '0;
        end else begin
            fetch_req_q <= fetch_req_d;
            halted_q    <= halted_d;
            param_q     <= param_d;
            ctrl_q      <= ctrl_d;
        end
    end

    assign fetch_req = fetch_req_q;
    assign PARAM     = param_q;
    assign prm_sel   = ctrl_q.prm_sel;
    assign pc_inc    = ctrl_q.pc_inc;
    assign jmp_load  = ctrl_q.jmp_load;
    assign mem_rd    = ctrl_q.mem_rd;
    assign mem_wr    = ctrl_q.mem_wr;
    assign alu_op    = ctrl_q.alu_op;
    assign illegal   = ctrl_q.illegal;
    assign fault     = fault_q;
    assign halted    = halted_q;

endmodule
